// File: rtl/rle_core_if.sv
// Coefficient-in / symbol-out bundle for rle_core.
// The master drives coefficients; the slave (rle_core) returns RLE symbols and flow control.
interface rle_core_if #(
  parameter int unsigned DATA_WIDTH = 12
);
  logic signed [DATA_WIDTH-1:0] data_in;
  logic                         din_valid;
  logic                         start;
  logic                         ready;
  logic [DATA_WIDTH+7:0]        rle_out;
  logic                         dovalid;
  logic                         buf_sel;
  logic                         block_done;

  modport master (
    output data_in, din_valid, start,
    input  ready, rle_out, dovalid, buf_sel, block_done
  );

  modport slave (
    input  data_in, din_valid, start,
    output ready, rle_out, dovalid, buf_sel, block_done
  );
endinterface

// File: rtl/rle_core.sv
// Run-length / size-amplitude coder for zigzag-ordered quantized blocks.
// Define RLE_DC_DIFF_EN to code each DC as the difference from the previous block's DC.
module rle_core #(
  parameter int unsigned DATA_WIDTH = 12,
  parameter int unsigned BLOCK_SIZE = 64
) (
  input  logic       clk,
  input  logic       reset,
  rle_core_if.slave  bus
);
  localparam int unsigned IdxW = (BLOCK_SIZE > 1) ? $clog2(BLOCK_SIZE) : 1;
  localparam int unsigned SymW = DATA_WIDTH + 8;
  localparam logic [IdxW-1:0] LastIdx = IdxW'(BLOCK_SIZE - 1);
  localparam logic [SymW-1:0] ZrlSym  = {4'hF, 4'h0, {DATA_WIDTH{1'b0}}};

  typedef enum logic [1:0] {StIdle, StRun, StFlushZrl} state_e;

  state_e          state_q, state_d;
  logic [IdxW-1:0] idx_q, idx_d;
  logic [3:0]      run_q, run_d;
  logic [1:0]      zrl_q, zrl_d;
  logic [SymW-1:0] pend_q, pend_d;
  logic            pend_last_q, pend_last_d;
  logic [SymW-1:0] rle_out_q, rle_out_d;
  logic            dovalid_q, dovalid_d;
  logic            block_done_q, block_done_d;
  logic            buf_sel_q, buf_sel_d;
  logic            ready_q, ready_d;

  logic signed [DATA_WIDTH-1:0] dc_val;
  logic                         take_dc, take_ac, is_last;
  logic [SymW-1:0]              ac_sym;

`ifdef RLE_DC_DIFF_EN
  logic [DATA_WIDTH-1:0] cur_dc_q, cur_dc_d, prev_dc_q, prev_dc_d;
  assign dc_val = $signed(bus.data_in - prev_dc_q);
`else
  assign dc_val = bus.data_in;
`endif

  // Returns {size, amplitude}; negative amplitude is value-1 (ones' complement of |value|).
  function automatic logic [DATA_WIDTH+3:0] encode(input logic signed [DATA_WIDTH-1:0] v);
    logic [DATA_WIDTH-1:0] mag, amp;
    logic [3:0]            sz;
    mag = $unsigned(v);
    amp = $unsigned(v);
    if (v[DATA_WIDTH-1]) begin
      mag = ~mag + DATA_WIDTH'(1);
      amp = amp - DATA_WIDTH'(1);
    end
    sz = '0;
    for (int i = 0; i < DATA_WIDTH; i++) begin
      if (mag[i]) sz = 4'(i + 1);
    end
    return {sz, amp};
  endfunction

  always_comb begin
    take_dc = bus.din_valid && bus.start && (state_q != StFlushZrl);
    take_ac = bus.din_valid && !bus.start && (state_q == StRun);
    is_last = (idx_q == LastIdx);
    ac_sym  = {run_q, encode(bus.data_in)};

    state_d      = state_q;
    idx_d        = idx_q;
    run_d        = run_q;
    zrl_d        = zrl_q;
    pend_d       = pend_q;
    pend_last_d  = pend_last_q;
    rle_out_d    = rle_out_q;
    dovalid_d    = 1'b0;
    block_done_d = 1'b0;
    buf_sel_d    = buf_sel_q ^ block_done_q;
`ifdef RLE_DC_DIFF_EN
    cur_dc_d  = cur_dc_q;
    prev_dc_d = prev_dc_q;
`endif

    if (take_dc) begin
      // A start always opens a new block, silently dropping any partial one.
      rle_out_d = {4'h0, encode(dc_val)};
      dovalid_d = 1'b1;
      idx_d     = IdxW'(1);
      run_d     = '0;
      zrl_d     = '0;
      state_d   = StRun;
`ifdef RLE_DC_DIFF_EN
      cur_dc_d  = bus.data_in;
`endif
    end else if (take_ac) begin
      idx_d = idx_q + IdxW'(1);
      if (bus.data_in == '0) begin
        if (is_last) begin
          rle_out_d    = '0;
          dovalid_d    = 1'b1;
          block_done_d = 1'b1;
          run_d        = '0;
          zrl_d        = '0;
          idx_d        = '0;
          state_d      = StIdle;
        end else if (run_q == 4'd15) begin
          run_d = '0;
          zrl_d = zrl_q + 2'd1;
        end else begin
          run_d = run_q + 4'd1;
        end
      end else begin
        dovalid_d = 1'b1;
        run_d     = '0;
        if (zrl_q != '0) begin
          // First ZRL goes out now; the rest and the symbol drain with ready low.
          rle_out_d   = ZrlSym;
          pend_d      = ac_sym;
          pend_last_d = is_last;
          zrl_d       = zrl_q - 2'd1;
          state_d     = StFlushZrl;
        end else begin
          rle_out_d = ac_sym;
          if (is_last) begin
            block_done_d = 1'b1;
            idx_d        = '0;
            state_d      = StIdle;
          end
        end
      end
    end else if (state_q == StFlushZrl) begin
      dovalid_d = 1'b1;
      if (zrl_q != '0) begin
        rle_out_d = ZrlSym;
        zrl_d     = zrl_q - 2'd1;
      end else begin
        rle_out_d = pend_q;
        if (pend_last_q) begin
          block_done_d = 1'b1;
          idx_d        = '0;
          state_d      = StIdle;
        end else begin
          state_d = StRun;
        end
      end
    end

`ifdef RLE_DC_DIFF_EN
    if (block_done_d) prev_dc_d = cur_dc_q;
`endif
    ready_d = (state_d != StFlushZrl);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q      <= StIdle;
      idx_q        <= '0;
      run_q        <= '0;
      zrl_q        <= '0;
      pend_q       <= '0;
      pend_last_q  <= 1'b0;
      rle_out_q    <= '0;
      dovalid_q    <= 1'b0;
      block_done_q <= 1'b0;
      buf_sel_q    <= 1'b0;
      ready_q      <= 1'b1;
`ifdef RLE_DC_DIFF_EN
      cur_dc_q     <= '0;
      prev_dc_q    <= '0;
`endif
    end else begin
      state_q      <= state_d;
      idx_q        <= idx_d;
      run_q        <= run_d;
      zrl_q        <= zrl_d;
      pend_q       <= pend_d;
      pend_last_q  <= pend_last_d;
      rle_out_q    <= rle_out_d;
      dovalid_q    <= dovalid_d;
      block_done_q <= block_done_d;
      buf_sel_q    <= buf_sel_d;
      ready_q      <= ready_d;
`ifdef RLE_DC_DIFF_EN
      cur_dc_q     <= cur_dc_d;
      prev_dc_q    <= prev_dc_d;
`endif
    end
  end

  assign bus.ready      = ready_q;
  assign bus.rle_out    = rle_out_q;
  assign bus.dovalid    = dovalid_q;
  assign bus.buf_sel    = buf_sel_q;
  assign bus.block_done = block_done_q;

endmodule

// File: tb/tb_rle_core.sv
// Randomized bench for rle_core: a block-level symbol model predicts each block's symbol list.
module tb_rle_core;
  localparam int Dw = 12;
  localparam int Bs = 64;

  logic clk = 1'b0;
  logic rst_n = 1'b1;
  always #5 clk = ~clk;

  rle_core_if #(.DATA_WIDTH(Dw)) bus ();

  rle_core #(.DATA_WIDTH(Dw), .BLOCK_SIZE(Bs)) dut (
    .clk   (clk),
    .reset (rst_n),
    .bus   (bus)
  );

  int checks = 0;
  int errors = 0;
  logic signed [11:0] coef [Bs];
  logic [20:0] exp_q [$];
  logic [20:0] got_q [$];
  int exp_low = 0;
  int low_cnt = 0;
  int blocks_done = 0;
`ifdef RLE_DC_DIFF_EN
  int prev_dc = 0;
`endif

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  always @(negedge clk) begin
    if (rst_n && bus.dovalid) got_q.push_back({bus.block_done, bus.rle_out});
    if (rst_n && !bus.ready) low_cnt++;
  end

  function automatic logic [19:0] sym(input int run, input int v);
    int mag = (v < 0) ? -v : v;
    int sz = 0;
    while ((1 << sz) <= mag) sz++;
    return 20'((run << 16) | (sz << 12) | (((v < 0) ? v - 1 : v) & 'hFFF));
  endfunction

  // Symbols the first n coefficients of coef[] should produce (a full block when n == Bs).
  function automatic void build_expect(input int n);
    int zeros = 0;
    int v;
    exp_q.delete();
    exp_low = 0;
    v = int'(coef[0]);
`ifdef RLE_DC_DIFF_EN
    v = (v - prev_dc) & 'hFFF;
    if (v >= 2048) v -= 4096;
`endif
    exp_q.push_back({1'b0, sym(0, v)});
    for (int i = 1; i < n; i++) begin
      v = int'(coef[i]);
      if (v == 0) begin
        zeros++;
        if (i == Bs - 1) exp_q.push_back(21'h0);
      end else begin
        for (int k = 0; k < zeros / 16; k++) exp_q.push_back({1'b0, 20'hF0000});
        exp_low += zeros / 16;
        exp_q.push_back({1'b0, sym(zeros % 16, v)});
        zeros = 0;
      end
    end
    if (n == Bs) begin
      exp_q[exp_q.size() - 1][20] = 1'b1;
      blocks_done++;
`ifdef RLE_DC_DIFF_EN
      prev_dc = int'(coef[0]);
`endif
    end
  endfunction

  function automatic logic [31:0] got_at(input int k);
    if (k < got_q.size()) return 32'(got_q[k]);
    return 32'hFFFF_FFFF;
  endfunction

  task automatic clear_obs();
    got_q.delete();
    low_cnt = 0;
  endtask

  // Caller sits at a negedge; returns at the negedge after the accepting posedge.
  task automatic push(input logic signed [11:0] v, input logic s);
    int guard = 0;
    while (!bus.ready && guard < 16) begin
      bus.din_valid = 1'b1;
      bus.start     = 1'b0;
      bus.data_in   = 12'($urandom);
      @(negedge clk);
      guard++;
    end
    if (!bus.ready) check_eq("ready_timeout", 32'(bus.ready), 32'd1);
    bus.data_in   = v;
    bus.din_valid = 1'b1;
    bus.start     = s;
    @(negedge clk);
    bus.din_valid = 1'b0;
    bus.start     = 1'b0;
  endtask

  task automatic drive_block(input int n);
    push(coef[0], 1'b1);
    check_eq("dc_latency", {11'b0, bus.dovalid, bus.rle_out}, {11'b0, 1'b1, exp_q[0][19:0]});
    for (int i = 1; i < n; i++) begin
      if ($urandom_range(3) == 0) @(negedge clk);
      push(coef[i], 1'b0);
    end
  endtask

  task automatic compare(input string tag);
    repeat (6) @(negedge clk);
    check_eq({tag, "_nsym"}, 32'(got_q.size()), 32'(exp_q.size()));
    foreach (exp_q[k]) check_eq($sformatf("%s_sym%0d", tag, k), got_at(k), 32'(exp_q[k]));
    check_eq({tag, "_ready_low"}, 32'(low_cnt), 32'(exp_low));
    check_eq({tag, "_buf_sel"}, 32'(bus.buf_sel), 32'(blocks_done % 2));
  endtask

  task automatic run_block(input int n, input string tag);
    build_expect(n);
    clear_obs();
    drive_block(n);
    compare(tag);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    check_eq("rst_rle_out", 32'(bus.rle_out), 32'd0);
    check_eq("rst_dovalid", 32'(bus.dovalid), 32'd0);
    check_eq("rst_block_done", 32'(bus.block_done), 32'd0);
    check_eq("rst_buf_sel", 32'(bus.buf_sel), 32'd0);
    check_eq("rst_ready", 32'(bus.ready), 32'd1);
    @(negedge clk);
    rst_n = 1'b1;
    blocks_done = 0;
`ifdef RLE_DC_DIFF_EN
    prev_dc = 0;
`endif
    clear_obs();
  endtask

  task automatic fill_random(input int pct);
    foreach (coef[i]) coef[i] = ($urandom_range(99) < pct) ? 12'($urandom) : 12'h000;
    coef[0] = 12'($urandom);
  endtask

  task automatic fill_zero();
    foreach (coef[i]) coef[i] = 12'sd0;
  endtask

  initial begin
    int pcts [5] = '{0, 3, 10, 40, 90};
    bus.data_in   = '0;
    bus.din_valid = 1'b0;
    bus.start     = 1'b0;
    do_reset();

    // Non-start input while idle must be ignored.
    bus.din_valid = 1'b1;
    bus.data_in   = 12'sd33;
    repeat (2) @(negedge clk);
    bus.din_valid = 1'b0;
    check_eq("idle_ignore", 32'(got_q.size()), 32'd0);

    fill_zero();
    coef[0] = 12'sd5;
    coef[1] = -12'sd3;
    run_block(Bs, "dc5");
    check_eq("dc5_lit0", got_at(0), 32'h003005);
    check_eq("dc5_lit1", got_at(1), 32'h002FFC);
    check_eq("dc5_eob", got_at(2), 32'h100000);

    do_reset();
    fill_zero();
    coef[21] = 12'sd7;
    run_block(Bs, "zrl1");
    check_eq("zrl1_lit1", got_at(1), 32'h0F0000);
    check_eq("zrl1_lit2", got_at(2), 32'h043007);
    check_eq("zrl1_low", 32'(low_cnt), 32'd1);

    do_reset();
    fill_zero();
    coef[0]  = 12'sd1;
    coef[63] = 12'sd1;
    run_block(Bs, "zrl3");
    check_eq("zrl3_lit0", got_at(0), 32'h001001);
    check_eq("zrl3_lit3", got_at(3), 32'h0F0000);
    check_eq("zrl3_last", got_at(4), 32'h1E1001);
    check_eq("zrl3_low", 32'(low_cnt), 32'd3);

    do_reset();
    fill_zero();
    coef[0] = 12'sd10;
    run_block(Bs, "dc10");
    coef[0] = 12'sd7;
    run_block(Bs, "dc7");

    fill_zero();
    coef[0]  = -12'sd2048;
    coef[1]  = -12'sd2048;
    coef[2]  = 12'sd2047;
    coef[3]  = -12'sd1;
    coef[20] = 12'sd1;
    coef[63] = -12'sd5;
    run_block(Bs, "extremes");

    for (int b = 0; b < 10; b++) begin
      fill_random(pcts[b % 5]);
      run_block(Bs, $sformatf("rnd%0d", b));
    end

    fill_random(20);
    run_block(30, "abort");
    fill_random(15);
    run_block(Bs, "after_abort");

    fill_random(20);
    clear_obs();
    for (int i = 0; i < 40; i++) push(coef[i], i == 0);
    do_reset();
    fill_random(15);
    run_block(Bs, "post_rst");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end
endmodule
